uart_tx_fifo_core: RTL

//  Next-generation UART transmitter: baud clock-enable generator, TX byte FIFO and framing FSM in a single clk domain.

---
 rtl/uart_tx_fifo_core.sv | 273 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_core.sv
// UART transmitter core: baud clock-enable generator, TX FIFO and framing FSM.
// Everything runs on clk; the baud tick is a one-cycle enable, never a clock.
module uart_tx_fifo_core #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CNT_W-1:0]                dvsr,
  input  logic [$clog2(DATA_W+1)-1:0]     data_len,
  input  logic                            parity_en,
  input  logic                            parity_odd,
  input  logic                            stop_2,
  input  logic                            wr_valid,
  input  logic [DATA_W-1:0]               wr_data,
  output logic                            wr_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            serial_out,
  output logic                            tx_busy,
  output logic                            tx_done,
  output logic [3:0]                      bit_cnt_out
);

  localparam int LEN_W  = $clog2(DATA_W + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } state_t;

  // Out-of-range lengths fall back to the full data width.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] r;
    if ((len < LEN_W'(5)) || (int'(len) > DATA_W)) begin
      r = LEN_W'(DATA_W);
    end else begin
      r = len;
    end
    return r;
  endfunction

  // Parity over the low len bits; odd=1 inverts so the total count of ones is odd.
  function automatic logic parity_bit(input logic [DATA_W-1:0] d,
                                      input logic [LEN_W-1:0]  len,
                                      input logic              odd);
    logic [DATA_W-1:0] mask;
    for (int i = 0; i < DATA_W; i++) begin
      mask[i] = (i < int'(len));
    end
    return (^(d & mask)) ^ odd;
  endfunction

  // ---------------- baud generator ----------------
  logic [CNT_W-1:0] baud_q, baud_d;
  logic             tick_s;

  // Free-running divisor counter; a lowered dvsr forces a wrap on the next clk.
  always_comb begin
    tick_s = (baud_q == dvsr);
    if (baud_q >= dvsr) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + CNT_W'(1);
    end
  end

  // Baud counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_q <= '0;
    end else begin
      baud_q <= baud_d;
    end
  end

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_FW-1:0] count_q, count_d;
  logic              full_s, empty_s, push_s, pop_s;

  assign full_s     = (count_q == CNT_FW'(FIFO_DEPTH));
  assign empty_s    = (count_q == CNT_FW'(0));
  assign wr_ready   = ~full_s;
  assign push_s     = wr_valid & ~full_s;
  assign fifo_count = count_q;

  // Pointer and occupancy update; simultaneous push and pop leave the count alone.
  always_comb begin
    wptr_d  = push_s ? (wptr_q + PTR_W'(1)) : wptr_q;
    rptr_d  = pop_s  ? (rptr_q + PTR_W'(1)) : rptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_FW'(1);
      2'b01:   count_d = count_q - CNT_FW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers; reset flushes the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= wr_data;
    end
  end

  // ---------------- framing FSM ----------------
  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              line_q, line_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [3:0]        bco_q, bco_d;
  logic              free_s;
  logic [LEN_W-1:0]  head_len_s;

  assign head_len_s = eff_len(data_len);

  // Next-state logic: advance only on tick; a free transmitter pops and starts a frame.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    len_d     = len_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    line_d    = line_q;
    done_d    = 1'b0;
    pop_s     = 1'b0;
    free_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        line_d = 1'b1;
        free_s = tick_s;
      end
      ST_START: begin
        if (tick_s) begin
          line_d    = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = 4'd0;
          state_d   = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if ((32'(bit_cnt_q) + 32'd1) < 32'(len_q)) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            line_d    = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end else if (par_en_q) begin
            bit_cnt_d = 4'd0;
            line_d    = par_bit_q;
            state_d   = ST_PARITY;
          end else begin
            bit_cnt_d = 4'd0;
            line_d    = 1'b1;
            state_d   = ST_STOP1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_s) begin
          line_d  = 1'b1;
          state_d = ST_STOP1;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP1: begin
        if (tick_s && stop2_q) begin
          state_d = ST_STOP2;
        end else begin
          free_s = tick_s;
          done_d = tick_s;
        end
      end
      ST_STOP2: begin
        free_s = tick_s;
        done_d = tick_s;
      end
      default: begin
        state_d = ST_IDLE;
        line_d  = 1'b1;
      end
    endcase

    if (free_s) begin
      if (!empty_s) begin
        pop_s     = 1'b1;
        shreg_d   = mem_q[rptr_q];
        len_d     = head_len_s;
        par_en_d  = parity_en;
        par_bit_d = parity_bit(mem_q[rptr_q], head_len_s, parity_odd);
        stop2_d   = stop_2;
        bit_cnt_d = 4'd0;
        line_d    = 1'b0;
        state_d   = ST_START;
      end else begin
        line_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end else begin
      pop_s = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
    bco_d  = (state_d == ST_DATA) ? bit_cnt_d : 4'd0;
  end

  // FSM state, frame configuration and registered line/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= 4'd0;
      len_q     <= LEN_W'(DATA_W);
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      line_q    <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      bco_q     <= 4'd0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      len_q     <= len_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
      line_q    <= line_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      bco_q     <= bco_d;
    end
  end

  assign serial_out  = line_q;
  assign tx_done     = done_q;
  assign tx_busy     = busy_q;
  assign bit_cnt_out = bco_q;

endmodule
